// File: rtl/hdmi_packet_pkg.sv
// Shared types and constants for the HDMI data-island packet path.
// Packet type codes, source selection and scheduler state.
package hdmi_packet_pkg;

  localparam logic [7:0] PT_NULL  = 8'h00;
  localparam logic [7:0] PT_ACR   = 8'h01;
  localparam logic [7:0] PT_AUDIO = 8'h02;
  localparam logic [7:0] PT_AVI   = 8'h82;
  localparam logic [7:0] PT_SPD   = 8'h83;
  localparam logic [7:0] PT_AIF   = 8'h84;

  localparam int ST_IF_OVR   = 0;
  localparam int ST_ACR_OVR  = 1;
  localparam int ST_SLOT_OVR = 2;

  typedef logic [3:0][55:0] sub_t;

  typedef enum logic [2:0] {
    SRC_NULL,
    SRC_ACR,
    SRC_AUD,
    SRC_AVI,
    SRC_AIF,
    SRC_SPD
  } src_sel_t;

  typedef enum logic {
    IDLE,
    EMIT
  } sched_state_t;

  // Fixed priority: ACR > audio > AVI > AIF > SPD > null.
  function automatic src_sel_t pick_source(
    input logic acr,
    input logic aud,
    input logic avi,
    input logic aif,
    input logic spd
  );
    if (acr)      return SRC_ACR;
    else if (aud) return SRC_AUD;
    else if (avi) return SRC_AVI;
    else if (aif) return SRC_AIF;
    else if (spd) return SRC_SPD;
    else          return SRC_NULL;
  endfunction

endpackage

// File: rtl/packet_slot_timer.sv
// Packet-period timer: accepts encoder slot requests and counts
// one packet period; flags requests that arrive mid-packet.
module packet_slot_timer
  import hdmi_packet_pkg::*;
#(
  parameter int PACKET_CYCLES = 32
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic packet_slot,
  output logic accept,
  output logic active,
  output logic overrun
);

  localparam int CW = (PACKET_CYCLES > 1) ? $clog2(PACKET_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PACKET_CYCLES - 1);

  sched_state_t    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and emit counter registers.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a slot on the last count restarts back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    overrun = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (packet_slot) begin
          accept  = 1'b1;
          state_d = EMIT;
          cnt_d   = '0;
        end
      end
      EMIT: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (packet_slot) accept = 1'b1;
          else             state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          overrun = packet_slot;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign active = (state_q == EMIT);

endmodule

// File: rtl/data_island_packet_scheduler.sv
// Data-island packet arbiter: tracks pending packet requests and
// latches one source's header/subpackets per packet slot.
module data_island_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int PACKET_CYCLES = 32,
  parameter int IF_PERIOD     = 1,
  parameter int SPD_ENABLE    = 1,
  parameter int AUDIO_ENABLE  = 1
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        packet_slot,
  input  logic        acr_req,
  input  logic        audio_valid,
  output logic        audio_ready,
  input  logic [23:0] acr_header,
  input  logic [23:0] aud_header,
  input  logic [23:0] avi_header,
  input  logic [23:0] aif_header,
  input  logic [23:0] spd_header,
  input  sub_t        acr_sub,
  input  sub_t        aud_sub,
  input  sub_t        avi_sub,
  input  sub_t        aif_sub,
  input  sub_t        spd_sub,
  output logic [23:0] header,
  output sub_t        sub,
  output logic [7:0]  packet_type,
  output logic        packet_active,
  output logic [2:0]  status
);

  localparam int FW = (IF_PERIOD > 1) ? $clog2(IF_PERIOD) : 1;
  localparam logic [FW-1:0] FLAST = FW'(IF_PERIOD - 1);

  logic          accept, slot_ovr;
  logic          acr_m, aud_m, arm;
  src_sel_t      sel;

  logic          acr_p_q, acr_p_d;
  logic          avi_p_q, avi_p_d;
  logic          aif_p_q, aif_p_d;
  logic          spd_p_q, spd_p_d;
  logic [FW-1:0] frm_q, frm_d;
  logic [23:0]   hdr_q, hdr_d;
  sub_t          sub_q, sub_d;
  logic          rdy_q, rdy_d;
  logic [2:0]    status_q, status_d;

  packet_slot_timer #(
    .PACKET_CYCLES(PACKET_CYCLES)
  ) u_timer (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .packet_slot(packet_slot),
    .accept     (accept),
    .active     (packet_active),
    .overrun    (slot_ovr)
  );

  assign acr_m = (AUDIO_ENABLE != 0) && acr_req;
  assign aud_m = (AUDIO_ENABLE != 0) && audio_valid;
  assign sel   = pick_source(acr_p_q, aud_m, avi_p_q,
                             aif_p_q, spd_p_q);
  // InfoFrames go out on frames whose index is 0 mod IF_PERIOD,
  // starting with the first frame after reset.
  assign arm   = frame_start && (frm_q == '0);

  // Pending flags, frame counter, selection and sticky status.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acr_p_q  <= 1'b0;
      avi_p_q  <= 1'b0;
      aif_p_q  <= 1'b0;
      spd_p_q  <= 1'b0;
      frm_q    <= '0;
      hdr_q    <= '0;
      sub_q    <= '0;
      rdy_q    <= 1'b0;
      status_q <= '0;
    end else begin
      acr_p_q  <= acr_p_d;
      avi_p_q  <= avi_p_d;
      aif_p_q  <= aif_p_d;
      spd_p_q  <= spd_p_d;
      frm_q    <= frm_d;
      hdr_q    <= hdr_d;
      sub_q    <= sub_d;
      rdy_q    <= rdy_d;
      status_q <= status_d;
    end
  end

  // Flag updates: selection clears first, same-cycle requests win.
  always_comb begin
    acr_p_d = acr_p_q;
    avi_p_d = avi_p_q;
    aif_p_d = aif_p_q;
    spd_p_d = spd_p_q;
    frm_d   = frm_q;
    if (accept) begin
      if (sel == SRC_ACR) acr_p_d = 1'b0;
      if (sel == SRC_AVI) avi_p_d = 1'b0;
      if (sel == SRC_AIF) aif_p_d = 1'b0;
      if (sel == SRC_SPD) spd_p_d = 1'b0;
    end
    if (acr_m) acr_p_d = 1'b1;
    if (frame_start) begin
      frm_d = (frm_q == FLAST) ? '0 : frm_q + 1'b1;
    end
    if (arm) begin
      avi_p_d = 1'b1;
      aif_p_d = 1'b1;
      if (SPD_ENABLE != 0) spd_p_d = 1'b1;
    end
  end

  // Output hold register loads only on an accepted slot.
  always_comb begin
    hdr_d = hdr_q;
    sub_d = sub_q;
    rdy_d = 1'b0;
    if (accept) begin
      unique case (sel)
        SRC_ACR: begin hdr_d = acr_header; sub_d = acr_sub; end
        SRC_AUD: begin hdr_d = aud_header; sub_d = aud_sub; end
        SRC_AVI: begin hdr_d = avi_header; sub_d = avi_sub; end
        SRC_AIF: begin hdr_d = aif_header; sub_d = aif_sub; end
        SRC_SPD: begin hdr_d = spd_header; sub_d = spd_sub; end
        default: begin hdr_d = '0;         sub_d = '0;      end
      endcase
      rdy_d = (sel == SRC_AUD);
    end
  end

  // Sticky error bits, judged against flags before this edge.
  always_comb begin
    status_d = status_q;
    if (slot_ovr)         status_d[ST_SLOT_OVR] = 1'b1;
    if (acr_m && acr_p_q) status_d[ST_ACR_OVR]  = 1'b1;
    if (arm && (avi_p_q || aif_p_q || spd_p_q))
      status_d[ST_IF_OVR] = 1'b1;
  end

  assign header      = hdr_q;
  assign sub         = sub_q;
  assign packet_type = hdr_q[7:0];
  assign audio_ready = rdy_q;
  assign status      = status_q;

endmodule

// File: tb/tb_data_island_packet_scheduler.sv
// Bench: directed scenarios then random traffic, two configurations
// checked cycle by cycle against a slot-level reference model.
module tb_data_island_packet_scheduler;
  import hdmi_packet_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        packet_slot = 1'b0;
  logic        acr_req = 1'b0;
  logic        audio_valid = 1'b0;
  logic [23:0] src_h [5];
  sub_t        src_s [5];

  logic        rdy_a, act_a, rdy_b, act_b;
  logic [23:0] hdr_a, hdr_b;
  sub_t        sub_a, sub_b;
  logic [7:0]  pt_a, pt_b;
  logic [2:0]  st_a, st_b;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  data_island_packet_scheduler u_a (
    .clk_pixel(clk), .reset(reset), .frame_start(frame_start),
    .packet_slot(packet_slot), .acr_req(acr_req),
    .audio_valid(audio_valid), .audio_ready(rdy_a),
    .acr_header(src_h[0]), .aud_header(src_h[1]),
    .avi_header(src_h[2]), .aif_header(src_h[3]),
    .spd_header(src_h[4]),
    .acr_sub(src_s[0]), .aud_sub(src_s[1]), .avi_sub(src_s[2]),
    .aif_sub(src_s[3]), .spd_sub(src_s[4]),
    .header(hdr_a), .sub(sub_a), .packet_type(pt_a),
    .packet_active(act_a), .status(st_a)
  );

  data_island_packet_scheduler #(
    .IF_PERIOD(2), .SPD_ENABLE(0)
  ) u_b (
    .clk_pixel(clk), .reset(reset), .frame_start(frame_start),
    .packet_slot(packet_slot), .acr_req(acr_req),
    .audio_valid(audio_valid), .audio_ready(rdy_b),
    .acr_header(src_h[0]), .aud_header(src_h[1]),
    .avi_header(src_h[2]), .aif_header(src_h[3]),
    .spd_header(src_h[4]),
    .acr_sub(src_s[0]), .aud_sub(src_s[1]), .avi_sub(src_s[2]),
    .aif_sub(src_s[3]), .spd_sub(src_s[4]),
    .header(hdr_b), .sub(sub_b), .packet_type(pt_b),
    .packet_active(act_b), .status(st_b)
  );

  // Reference model: sources indexed in priority order
  // 0 ACR, 1 audio, 2 AVI, 3 AIF, 4 SPD.
  typedef struct {
    int          left;
    int          frames;
    bit [4:0]    pend;
    logic [23:0] hdr;
    sub_t        sub;
    bit          rdy;
    bit [2:0]    st;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mzero();
    mdl_t z;
    z.left = 0; z.frames = 0; z.pend = '0;
    z.hdr = '0; z.sub = '0; z.rdy = 1'b0; z.st = '0;
    return z;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int ifp, bit spd_en,
                                 bit r, bit s, bit a, bit f, bit v);
    mdl_t n;
    bit [4:0] avail;
    bit acc, found;
    if (r) return mzero();
    n = m;
    n.rdy = 1'b0;
    avail = m.pend;
    avail[1] = v;
    acc = s && (m.left <= 1);
    if (s && m.left > 1) n.st[2] = 1'b1;
    n.left = acc ? 32 : (m.left > 0 ? m.left - 1 : 0);
    if (acc) begin
      n.hdr = '0;
      n.sub = '0;
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (!found && avail[i]) begin
          found = 1'b1;
          n.hdr = src_h[i];
          n.sub = src_s[i];
          n.pend[i] = 1'b0;
          n.rdy = (i == 1);
        end
      end
    end
    if (a) begin
      if (m.pend[0]) n.st[1] = 1'b1;
      n.pend[0] = 1'b1;
    end
    if (f) begin
      if (m.frames % ifp == 0) begin
        for (int i = 2; i < 5; i++) begin
          if (i != 4 || spd_en) begin
            if (m.pend[i]) n.st[0] = 1'b1;
            n.pend[i] = 1'b1;
          end
        end
      end
      n.frames = m.frames + 1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [223:0] obs,
                     input logic [223:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_sources();
    logic [7:0]  tc [5];
    logic [31:0] t;
    tc[0] = PT_ACR; tc[1] = PT_AUDIO; tc[2] = PT_AVI;
    tc[3] = PT_AIF; tc[4] = PT_SPD;
    for (int i = 0; i < 5; i++) begin
      t = $urandom();
      src_h[i] = {t[15:0], tc[i]};
      for (int w = 0; w < 4; w++)
        src_s[i][w] = 56'({$urandom(), $urandom()});
    end
  endtask

  task automatic cyc(input bit s = 0, input bit a = 0,
                     input bit f = 0, input bit v = 0,
                     input bit r = 0);
    @(negedge clk);
    reset = r; packet_slot = s; acr_req = a;
    frame_start = f; audio_valid = v;
    randomize_sources();
    ma = mstep(ma, 1, 1'b1, r, s, a, f, v);
    mb = mstep(mb, 2, 1'b0, r, s, a, f, v);
    @(posedge clk);
    #1;
    chk("a.header", hdr_a, ma.hdr);
    chk("a.sub", sub_a, ma.sub);
    chk("a.type", pt_a, ma.hdr[7:0]);
    chk("a.ctl", {act_a, rdy_a, st_a},
        {ma.left > 0, ma.rdy, ma.st});
    chk("b.header", hdr_b, mb.hdr);
    chk("b.sub", sub_b, mb.sub);
    chk("b.type", pt_b, mb.hdr[7:0]);
    chk("b.ctl", {act_b, rdy_b, st_b},
        {mb.left > 0, mb.rdy, mb.st});
  endtask

  task automatic idle(input int n, input bit v = 0);
    repeat (n) cyc(.v(v));
  endtask

  initial begin
    logic [7:0] e1 [4];
    logic [7:0] e5 [3];
    bit s, a, f, r;
    bit v;
    ma = mzero();
    mb = mzero();
    e1[0] = PT_AVI; e1[1] = PT_AIF; e1[2] = PT_SPD; e1[3] = PT_NULL;
    e5[0] = PT_AVI; e5[1] = PT_AIF; e5[2] = PT_NULL;

    // reset state
    cyc(.r(1)); cyc(.r(1));
    chk("rst.header", hdr_a, 24'h0);
    chk("rst.sub", sub_a, '0);
    chk("rst.ctl", {act_a, rdy_a, st_a, pt_a}, '0);

    // one frame of InfoFrames, slots 32 cycles apart
    cyc(.f(1));
    for (int k = 0; k < 4; k++) begin
      cyc(.s(1));
      chk("t1.type", pt_a, e1[k]);
      chk("t1.active", act_a, 1'b1);
      idle(31);
    end

    // ACR beats audio; audio next with one ready pulse
    cyc(.a(1), .v(1));
    cyc(.s(1), .v(1));
    chk("t2.acr", pt_a, PT_ACR);
    chk("t2.rdy0", rdy_a, 1'b0);
    idle(31, 1'b1);
    cyc(.s(1), .v(1));
    chk("t2.aud", pt_a, PT_AUDIO);
    chk("t2.rdy1", rdy_a, 1'b1);
    cyc();
    chk("t2.rdy2", rdy_a, 1'b0);
    idle(31);

    // slot at count 10 is ignored even with ACR pending
    cyc(.s(1));
    idle(4);
    cyc(.a(1));
    idle(5);
    cyc(.s(1));
    chk("t3.type", pt_a, PT_NULL);
    chk("t3.slotovr", st_a[2], 1'b1);
    idle(21);
    cyc(.s(1));
    chk("t3.acr", pt_a, PT_ACR);
    idle(32);

    // two frames without slots: overrun, no duplicates
    cyc(.f(1)); cyc(.f(1));
    chk("t4.ifovr", st_a[0], 1'b1);
    chk("t4.sticky", st_a[2], 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(.s(1));
      chk("t4.type", pt_a, e1[k]);
      idle(31);
    end

    // IF_PERIOD=2, no SPD: InfoFrames on even frames only
    cyc(.r(1));
    for (int fr = 0; fr < 4; fr++) begin
      cyc(.f(1));
      for (int k = 0; k < 3; k++) begin
        cyc(.s(1));
        chk("t5.type", pt_b, (fr % 2 == 0) ? e5[k] : PT_NULL);
        idle(31);
      end
    end

    // reset in the middle of an ACR packet
    cyc(.a(1)); cyc(.a(1));
    chk("t6.acrovr", st_a[1], 1'b1);
    cyc(.s(1));
    chk("t6.acr", pt_a, PT_ACR);
    idle(15);
    cyc(.r(1));
    chk("t6.header", hdr_a, 24'h0);
    chk("t6.active", act_a, 1'b0);
    chk("t6.status", st_a, 3'b000);
    cyc(.s(1));
    chk("t6.discard", pt_a, PT_NULL);
    idle(32);

    // random traffic against the model
    v = 1'b0;
    repeat (3000) begin
      s = ($urandom_range(19) == 0);
      a = ($urandom_range(39) == 0);
      f = ($urandom_range(99) == 0);
      r = ($urandom_range(499) == 0);
      if ($urandom_range(7) == 0) v = ~v;
      cyc(.s(s), .a(a), .f(f), .v(v), .r(r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
